// File: rtl/i2c_pt_pkg.sv
// Shared types and constants for the I2C passthrough front end.
//   state_t    : protocol phase tracked by i2c_bus_tracker
//   DIR_*      : SDA buffer direction encoding
//   state_dir(): direction implied by a protocol phase
package i2c_pt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  localparam logic DIR_MASTER = 1'b0;
  localparam logic DIR_SLAVE  = 1'b1;

  localparam int                    BIT_CNT_W  = 4;
  localparam logic [BIT_CNT_W-1:0]  BYTE_DONE  = 4'd8;
  localparam int                    IDLE_CNT_W = 17;

  // The slave owns SDA while it acks the master, and while it returns read data.
  function automatic logic state_dir(input state_t s);
    case (s)
      ADDR_ACK, WR_ACK, RD_DATA: return DIR_SLAVE;
      default:                   return DIR_MASTER;
    endcase
  endfunction

endpackage

// File: rtl/i2c_sync_filter.sv
// Two-flop synchronizer followed by a glitch filter for one asynchronous pin.
//   system_clk : system clock
//   reset      : synchronous active-low reset; all stages load 1 (idle bus)
//   pin        : raw asynchronous pin
//   level      : filtered level; follows the synchronized pin only after it has
//                disagreed for FILTER_LEN consecutive cycles
module i2c_sync_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic system_clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam int            CW   = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge system_clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      // Any cycle of agreement restarts the run, so short glitches never pass.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_tracker.sv
// Protocol tracker for the I2C passthrough. Decodes START / STOP / repeated
// START, the address byte, R/W, data and ACK phases from the filtered bus and
// drives the SDA buffer direction.
//   system_clk    : system clock
//   reset         : synchronous active-low reset
//   master_scl    : raw master SCL pin
//   master_sda    : raw master SDA pin
//   slave_sda_in  : raw SDA level returned from the slave side
//   sda_direction : 0 = master drives toward slave, 1 = slave drives toward master
//   start_stop    : one-cycle pulse on START, repeated START or STOP
//   incycle       : high from START until STOP, timeout or reset
//   addr_byte     : last captured {addr[6:0], rw}
//   addr_valid    : one-cycle pulse when addr_byte updates
//   timeout       : one-cycle pulse on a stalled-clock abort
module i2c_bus_tracker
  import i2c_pt_pkg::*;
#(
  parameter int FILTER_LEN  = 3,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic       master_scl,
  input  logic       master_sda,
  input  logic       slave_sda_in,
  output logic       sda_direction,
  output logic       start_stop,
  output logic       incycle,
  output logic [7:0] addr_byte,
  output logic       addr_valid,
  output logic       timeout
);

  localparam logic [IDLE_CNT_W-1:0] TO_LIM = IDLE_CNT_W'(TIMEOUT_CYC);
  localparam logic                  TO_EN  = (TIMEOUT_CYC != 0);

  logic scl_f, sda_f, slv_f;
  logic scl_q, sda_q;

  i2c_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .system_clk(system_clk), .reset(reset), .pin(master_scl),   .level(scl_f));
  i2c_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .system_clk(system_clk), .reset(reset), .pin(master_sda),   .level(sda_f));
  i2c_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_slv (
    .system_clk(system_clk), .reset(reset), .pin(slave_sda_in), .level(slv_f));

  state_t                 state, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_d;
  logic [7:0]             shift, shift_d;
  logic                   ack_bit, ack_bit_d;
  logic [IDLE_CNT_W-1:0]  idle_cnt, idle_cnt_d;
  logic [7:0]             addr_d;
  logic                   incycle_d, start_stop_d, addr_valid_d, timeout_d;

  logic scl_rise, scl_fall, start_det, stop_det, timeout_hit;

  assign scl_rise  =  scl_f & ~scl_q;
  assign scl_fall  = ~scl_f &  scl_q;
  // SCL must be high on both sides of the SDA edge; an SDA move next to an SCL
  // edge is treated as data.
  assign start_det =  sda_q & ~sda_f & scl_f & scl_q;
  assign stop_det  = ~sda_q &  sda_f & scl_f & scl_q;
  assign timeout_hit = TO_EN && incycle && !scl_rise && !scl_fall &&
                       ((idle_cnt + 1'b1) == TO_LIM);

  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    shift_d      = shift;
    ack_bit_d    = ack_bit;
    idle_cnt_d   = idle_cnt;
    addr_d       = addr_byte;
    incycle_d    = incycle;
    start_stop_d = 1'b0;
    addr_valid_d = 1'b0;
    timeout_d    = 1'b0;

    if (start_det) begin
      state_d      = ADDR;
      bit_cnt_d    = '0;
      incycle_d    = 1'b1;
      start_stop_d = 1'b1;
      idle_cnt_d   = '0;
    end else if (stop_det) begin
      state_d      = IDLE;
      incycle_d    = 1'b0;
      start_stop_d = 1'b1;
      idle_cnt_d   = '0;
    end else if (timeout_hit) begin
      state_d    = IDLE;
      incycle_d  = 1'b0;
      timeout_d  = 1'b1;
      idle_cnt_d = '0;
    end else begin
      if (scl_rise || scl_fall) idle_cnt_d = '0;
      else if (incycle)         idle_cnt_d = idle_cnt + 1'b1;

      // Rising edge: sample only, no phase change.
      if (scl_rise) begin
        case (state)
          ADDR: begin
            shift_d   = {shift[6:0], sda_f};
            bit_cnt_d = bit_cnt + 1'b1;
          end
          WR_DATA, RD_DATA: bit_cnt_d = bit_cnt + 1'b1;
          ADDR_ACK, WR_ACK: ack_bit_d = slv_f;
          RD_ACK:           ack_bit_d = sda_f;
          default: ;
        endcase
      end

      // Falling edge: phase (and therefore direction) changes here only.
      if (scl_fall) begin
        case (state)
          ADDR: if (bit_cnt == BYTE_DONE) begin
            addr_d       = shift;
            addr_valid_d = 1'b1;
            bit_cnt_d    = '0;
            state_d      = ADDR_ACK;
          end
          ADDR_ACK: begin
            if (ack_bit)           state_d = WAIT_STOP;
            else if (addr_byte[0]) state_d = RD_DATA;
            else                   state_d = WR_DATA;
          end
          WR_DATA: if (bit_cnt == BYTE_DONE) begin
            bit_cnt_d = '0;
            state_d   = WR_ACK;
          end
          WR_ACK:  state_d = ack_bit ? WAIT_STOP : WR_DATA;
          RD_DATA: if (bit_cnt == BYTE_DONE) begin
            bit_cnt_d = '0;
            state_d   = RD_ACK;
          end
          RD_ACK:  state_d = ack_bit ? WAIT_STOP : RD_DATA;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge system_clk) begin
    if (!reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      ack_bit       <= 1'b1;
      idle_cnt      <= '0;
      scl_q         <= 1'b1;
      sda_q         <= 1'b1;
      sda_direction <= DIR_MASTER;
      start_stop    <= 1'b0;
      incycle       <= 1'b0;
      addr_byte     <= 8'h00;
      addr_valid    <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state         <= state_d;
      bit_cnt       <= bit_cnt_d;
      shift         <= shift_d;
      ack_bit       <= ack_bit_d;
      idle_cnt      <= idle_cnt_d;
      scl_q         <= scl_f;
      sda_q         <= sda_f;
      sda_direction <= state_dir(state_d);
      start_stop    <= start_stop_d;
      incycle       <= incycle_d;
      addr_byte     <= addr_d;
      addr_valid    <= addr_valid_d;
      timeout       <= timeout_d;
    end
  end

endmodule

// File: tb/tb_i2c_bus_tracker.sv
// Bus-level bench for i2c_bus_tracker: drives whole I2C transactions and checks
// direction per bit slot, captured addresses and event pulses against the
// protocol's ownership rules.
module tb_i2c_bus_tracker;

  localparam int FL  = 3;
  localparam int TO  = 50;
  localparam int H   = 10;   // SCL half period in system clocks
  localparam int LAT = FL + 3;

  logic       system_clk = 1'b0;
  logic       reset = 1'b0;
  logic       master_scl = 1'b1, master_sda = 1'b1, slave_sda_in = 1'b1;
  logic       sda_direction, start_stop, incycle, addr_valid, timeout;
  logic [7:0] addr_byte;

  i2c_bus_tracker #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .system_clk(system_clk), .reset(reset), .master_scl(master_scl),
    .master_sda(master_sda), .slave_sda_in(slave_sda_in),
    .sda_direction(sda_direction), .start_stop(start_stop), .incycle(incycle),
    .addr_byte(addr_byte), .addr_valid(addr_valid), .timeout(timeout));

  always #5 system_clk = ~system_clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int ss_cnt = 0, to_cnt = 0, to_cyc = 0;
  int ss_cyc_q[$];
  logic [7:0] av_q[$];
  bit mon_en = 0, saw_incycle = 0;
  logic [7:0] xdata[4];
  bit         xack[4];

  always @(posedge system_clk) cyc <= cyc + 1;

  always @(negedge system_clk) if (mon_en) begin
    if (start_stop) begin ss_cnt++; ss_cyc_q.push_back(cyc); end
    if (addr_valid) av_q.push_back(addr_byte);
    if (timeout) begin to_cnt++; to_cyc = cyc; end
    if (incycle) saw_incycle = 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge system_clk);
    #1;
  endtask

  // One bit slot, entered and left with SCL low; data changes only while low.
  task automatic slot(input logic m, input logic s, input logic dir, input string nm);
    tick(2); master_sda = m; slave_sda_in = s; tick(H - 2);
    master_scl = 1'b1; tick(7);
    n_chk++;
    if (sda_direction !== dir) begin
      n_fail++;
      $display("FAIL %s: sda_direction=%b expected %b at cycle %0d", nm, sda_direction, dir, cyc);
    end
    tick(H - 7); master_scl = 1'b0;
  endtask

  task automatic bus_idle();
    master_scl = 1'b1; master_sda = 1'b1; slave_sda_in = 1'b1; tick(2 * H);
  endtask
  task automatic bus_start();
    master_sda = 1'b0; tick(H); master_scl = 1'b0;
  endtask
  task automatic bus_rstart();
    tick(2); master_sda = 1'b1; slave_sda_in = 1'b1; tick(H - 2);
    master_scl = 1'b1; tick(H); master_sda = 1'b0; tick(H); master_scl = 1'b0;
  endtask
  task automatic bus_stop();
    tick(2); master_sda = 1'b0; slave_sda_in = 1'b1; tick(H - 2);
    master_scl = 1'b1; tick(H); master_sda = 1'b1; tick(H);
  endtask

  // Address byte plus n data bytes (xdata/xack). Expected owner per slot:
  // master for address/write bits and for the read ack, slave for the address
  // ack, write acks and read bits; after any NACK the master keeps SDA.
  task automatic xfer(input logic [7:0] ab, input bit a_ack, input int n);
    logic [7:0] got;
    for (int i = 7; i >= 0; i--) slot(ab[i], 1'b1, 1'b0, "addr_bit_dir");
    slot(1'b1, !a_ack, 1'b1, "addr_ack_dir");
    n_chk++;
    if (av_q.size() != 1 || incycle !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_valid_count: pulses=%0d incycle=%b expected 1 and 1", av_q.size(), incycle);
    end
    if (av_q.size() > 0) begin
      got = av_q.pop_front();
      n_chk++;
      if (got !== ab) begin
        n_fail++; $display("FAIL addr_byte: got %h expected %h", got, ab);
      end
    end
    av_q.delete();
    if (!a_ack) begin
      slot(1'b1, 1'b1, 1'b0, "nack_tail_dir"); slot(1'b0, 1'b1, 1'b0, "nack_tail_dir");
      return;
    end
    for (int b = 0; b < n; b++) begin
      if (!ab[0]) begin
        for (int i = 7; i >= 0; i--) slot(xdata[b][i], 1'b1, 1'b0, "wr_bit_dir");
        slot(1'b1, !xack[b], 1'b1, "wr_ack_dir");
      end else begin
        for (int i = 7; i >= 0; i--) slot(1'b1, xdata[b][i], 1'b1, "rd_bit_dir");
        slot(!xack[b], 1'b1, 1'b0, "rd_ack_dir");
      end
      if (!xack[b]) begin
        slot(1'b1, 1'b1, 1'b0, "nack_tail_dir"); slot(1'b0, 1'b0, 1'b0, "nack_tail_dir");
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; tick(4); reset = 1'b1; tick(1); mon_en = 1;
    n_chk++;
    if ({sda_direction, start_stop, incycle, addr_valid, timeout} !== 5'b0 || addr_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: dir=%b ss=%b inc=%b av=%b to=%b addr=%h expected all 0",
               sda_direction, start_stop, incycle, addr_valid, timeout, addr_byte);
    end
    tick(20);
    n_chk++;
    if (ss_cnt != 0 || incycle !== 1'b0) begin
      n_fail++; $display("FAIL reset_quiet: start_stop pulses=%0d incycle=%b expected 0 and 0", ss_cnt, incycle);
    end
  endtask

  task automatic test_glitch();
    int ss0, c0;
    bus_idle();
    ss0 = ss_cnt; saw_incycle = 0;
    master_sda = 1'b0; tick(2); master_sda = 1'b1; tick(20);
    n_chk++;
    if (ss_cnt != ss0 || saw_incycle) begin
      n_fail++; $display("FAIL glitch_short: pulses=%0d incycle_seen=%b expected 0 and 0", ss_cnt - ss0, saw_incycle);
    end
    ss_cyc_q.delete(); ss0 = ss_cnt; c0 = cyc;
    master_sda = 1'b0; tick(4); master_sda = 1'b1; tick(20);
    n_chk++;
    if (ss_cnt - ss0 != 2 || !saw_incycle) begin
      n_fail++; $display("FAIL glitch_long: pulses=%0d incycle_seen=%b expected 2 and 1", ss_cnt - ss0, saw_incycle);
    end
    n_chk++;
    if (ss_cyc_q.size() == 0 || ss_cyc_q[0] - c0 != LAT) begin
      n_fail++; $display("FAIL start_latency: got %0d expected %0d", ss_cyc_q.size() ? ss_cyc_q[0] - c0 : -1, LAT);
    end
  endtask

  task automatic test_write();
    int ss0;
    bus_idle(); ss0 = ss_cnt;
    bus_start(); xdata[0] = 8'hAA; xack[0] = 1; xfer(8'h4E, 1, 1); bus_stop();
    n_chk++;
    if (ss_cnt - ss0 != 2 || incycle !== 1'b0 || addr_byte !== 8'h4E) begin
      n_fail++; $display("FAIL write_xfer: pulses=%0d incycle=%b addr=%h expected 2, 0, 4e", ss_cnt - ss0, incycle, addr_byte);
    end
  endtask

  task automatic test_read_sr();
    int ss0;
    bus_idle(); ss0 = ss_cnt;
    bus_start(); xdata[0] = 8'hAA; xack[0] = 1; xfer(8'h4E, 1, 1);
    bus_rstart(); xdata[0] = 8'h55; xack[0] = 0; xfer(8'h4F, 1, 1);
    bus_stop();
    n_chk++;
    if (ss_cnt - ss0 != 3 || incycle !== 1'b0 || sda_direction !== 1'b0) begin
      n_fail++; $display("FAIL read_sr: pulses=%0d incycle=%b dir=%b expected 3, 0, 0", ss_cnt - ss0, incycle, sda_direction);
    end
  endtask

  task automatic test_addr_nack();
    int ss0;
    bus_idle(); ss0 = ss_cnt;
    bus_start(); xfer(8'hA0, 0, 0); bus_stop();
    n_chk++;
    if (ss_cnt - ss0 != 2 || incycle !== 1'b0) begin
      n_fail++; $display("FAIL addr_nack: pulses=%0d incycle=%b expected 2 and 0", ss_cnt - ss0, incycle);
    end
  endtask

  task automatic test_random();
    int ss0, n;
    logic [7:0] ab;
    bit aa;
    for (int t = 0; t < 8; t++) begin
      ab = 8'($urandom); aa = ($urandom_range(0, 6) != 0); n = $urandom_range(1, 3);
      for (int b = 0; b < 4; b++) begin xdata[b] = 8'($urandom); xack[b] = ($urandom_range(0, 3) != 0); end
      bus_idle(); ss0 = ss_cnt;
      bus_start(); xfer(ab, aa, n); bus_stop();
      n_chk++;
      if (ss_cnt - ss0 != 2 || incycle !== 1'b0 || addr_byte !== ab) begin
        n_fail++; $display("FAIL random_xfer %0d: pulses=%0d incycle=%b addr=%h expected 2, 0, %h",
                           t, ss_cnt - ss0, incycle, addr_byte, ab);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int ss0;
    bus_idle();
    bus_start(); xfer(8'h4F, 1, 0);
    for (int i = 0; i < 3; i++) slot(1'b1, 1'b0, 1'b1, "rd_bit_dir");
    tick(2); slave_sda_in = 1'b1; tick(H - 2); master_scl = 1'b1; tick(4);
    n_chk++;
    if (sda_direction !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_dir: got %b expected 1", sda_direction);
    end
    reset = 1'b0; tick(1); reset = 1'b1;
    n_chk++;
    if (sda_direction !== 1'b0 || incycle !== 1'b0 || addr_byte !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid_read: dir=%b incycle=%b addr=%h expected 0, 0, 00",
                         sda_direction, incycle, addr_byte);
    end
    tick(H); master_scl = 1'b0; tick(H);
    bus_idle(); ss0 = ss_cnt;
    bus_start(); xdata[0] = 8'h3C; xack[0] = 1; xfer(8'h92, 1, 1); bus_stop();
    n_chk++;
    if (ss_cnt - ss0 != 2 || addr_byte !== 8'h92) begin
      n_fail++; $display("FAIL post_reset_xfer: pulses=%0d addr=%h expected 2 and 92", ss_cnt - ss0, addr_byte);
    end
  endtask

  task automatic test_timeout();
    int ss0, to0, c0, lat;
    bit seen;
    bus_idle(); ss0 = ss_cnt; to0 = to_cnt;
    bus_start();
    for (int i = 7; i >= 5; i--) slot(1'b1, 1'b1, 1'b0, "addr_bit_dir");
    c0 = cyc;
    tick(TO - 5);
    n_chk++;
    if (to_cnt != to0 || incycle !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early: pulses=%0d incycle=%b expected 0 and 1", to_cnt - to0, incycle);
    end
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin tick(1); seen = (to_cnt != to0); end
    lat = to_cyc - c0;
    n_chk++;
    if (!seen || to_cnt - to0 != 1 || lat < TO + LAT - 1 || lat > TO + LAT + 1) begin
      n_fail++; $display("FAIL timeout_pulse: pulses=%0d latency=%0d expected 1 near %0d", to_cnt - to0, lat, TO + LAT);
    end
    n_chk++;
    if (incycle !== 1'b0 || sda_direction !== 1'b0 || ss_cnt != ss0 + 1) begin
      n_fail++; $display("FAIL timeout_abort: incycle=%b dir=%b start_stop=%0d expected 0, 0, 1",
                         incycle, sda_direction, ss_cnt - ss0);
    end
    master_sda = 1'b1; tick(H);
    bus_idle(); ss0 = ss_cnt;
    bus_start(); xdata[0] = 8'h81; xack[0] = 1; xfer(8'h4E, 1, 1); bus_stop();
    n_chk++;
    if (ss_cnt - ss0 != 2 || addr_byte !== 8'h4E || to_cnt != to0 + 1) begin
      n_fail++; $display("FAIL post_timeout_xfer: pulses=%0d addr=%h timeouts=%0d expected 2, 4e, 1",
                         ss_cnt - ss0, addr_byte, to_cnt - to0);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_write();
    test_read_sr();
    test_addr_nack();
    test_random();
    test_reset_mid_read();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
